datapath_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 16-bit datapath: instruction fetch, decode, execute, memory access and register writeback.
- Instruction format: opcode[15:12], rd[11:8], imm8[7:0].
- The datapath sign-extends imm8 to 16 bits; this block tells it when to select the extended immediate.
- Drives all datapath enables and selects.
- Handles memory through a req/ready handshake with a bounded wait timeout.

---
 rtl/datapath_pkg.sv | 39 +++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/datapath_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the datapath sequencer.
// Instruction word: opcode[15:12], rd[11:8], imm8[7:0].
package datapath_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_e;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_BEQ  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits; expired flags the cycle the count would reach MEM_TIMEOUT.
// Zero latency on expired; MEM_TIMEOUT = 0 never expires.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // The wait cycle that brings the count to the limit is the last one tolerated.
   assign expired = (MEM_TIMEOUT != 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; memory waits on req/ready with bounded timeout.
// SEQ_PERF_COUNTERS_EN adds instr_retired/stall_cycles saturating counters.
module datapath_sequencer
   import datapath_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] instr,
   input  logic        mem_ready,
   input  logic        alu_zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic        ir_load,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        alu_src_imm,
   output logic [2:0]  alu_op,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        busy,
   output logic        halted,
`ifdef SEQ_PERF_COUNTERS_EN
   output logic [15:0] instr_retired,
   output logic [15:0] stall_cycles,
`endif
   output logic        error
);

   state_e      state_q, state_d;
   logic [15:0] ir_q;
   logic [3:0]  opcode;
   logic        wait_inc, timer_clr, timer_expired;
   logic        unused_ir_bits;

   assign opcode         = ir_q[OPC_MSB:OPC_LSB];
   assign unused_ir_bits = ^ir_q[RD_MSB:IMM_LSB];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ir_load)
            ir_q <= instr;
      end
   end

   assign wait_inc  = rst_n && ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
   assign timer_clr = mem_ready ||
                      ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)));

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr),
      .inc     (wait_inc),
      .expired (timer_expired)
   );

   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_load     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = ALU_ADD;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      busy        = 1'b1;
      halted      = 1'b0;
      error       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load = 1'b1;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end else if (timer_expired) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            unique case (opcode)
               OP_NOP:                            state_d = S_FETCH;
               OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_ADDI, OP_LD, OP_ST, OP_BEQ:     state_d = S_EXEC;
               OP_HALT:                           state_d = S_HALT;
               default:                           state_d = S_ERROR;
            endcase
         end
         S_EXEC: begin
            unique case (opcode)
               OP_ADD:  begin alu_op = ALU_ADD; state_d = S_WB; end
               OP_SUB:  begin alu_op = ALU_SUB; state_d = S_WB; end
               OP_AND:  begin alu_op = ALU_AND; state_d = S_WB; end
               OP_OR:   begin alu_op = ALU_OR;  state_d = S_WB; end
               OP_ADDI: begin alu_src_imm = 1'b1; state_d = S_WB; end
               OP_LD, OP_ST: begin alu_src_imm = 1'b1; state_d = S_MEM; end
               OP_BEQ: begin
                  alu_op  = ALU_SUB;
                  pc_load = alu_zero;
                  state_d = S_FETCH;
               end
               default: state_d = S_ERROR;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (opcode == OP_ST);
            if (mem_ready)
               state_d = (opcode == OP_LD) ? S_WB : S_FETCH;
            else if (timer_expired)
               state_d = S_ERROR;
         end
         S_WB: begin
            reg_we  = 1'b1;
            wb_sel  = (opcode == OP_LD);
            state_d = S_FETCH;
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         S_ERROR: begin
            busy  = 1'b0;
            error = 1'b1;
         end
         default: state_d = S_ERROR;
      endcase
      // Reset silences every output in the reset cycle itself, even mid-handshake.
      if (!rst_n) begin
         mem_req     = 1'b0;
         mem_we      = 1'b0;
         ir_load     = 1'b0;
         pc_inc      = 1'b0;
         pc_load     = 1'b0;
         alu_src_imm = 1'b0;
         alu_op      = ALU_ADD;
         reg_we      = 1'b0;
         wb_sel      = 1'b0;
         busy        = 1'b0;
         halted      = 1'b0;
         error       = 1'b0;
      end
   end

`ifdef SEQ_PERF_COUNTERS_EN
   logic [15:0] retired_q, stall_q;
   logic        retire;

   assign retire = (state_d == S_FETCH) &&
                   (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (retire && (retired_q != 16'hFFFF))
            retired_q <= retired_q + 16'd1;
         if (wait_inc && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
      end
   end

   assign instr_retired = retired_q;
   assign stall_cycles  = stall_q;
`else
   // No performance state in this build.
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer with MEM_TIMEOUT=4; outputs sampled 1-2 ns after the rising edge.
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, start, mem_ready, alu_zero;
   logic [15:0] instr;
   logic        mem_req, mem_we, ir_load, pc_inc, pc_load, alu_src_imm;
   logic [2:0]  alu_op;
   logic        reg_we, wb_sel, busy, halted, error;
`ifdef SEQ_PERF_COUNTERS_EN
   logic [15:0] instr_retired, stall_cycles;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   datapath_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .instr       (instr),
      .mem_ready   (mem_ready),
      .alu_zero    (alu_zero),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .ir_load     (ir_load),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .alu_src_imm (alu_src_imm),
      .alu_op      (alu_op),
      .reg_we      (reg_we),
      .wb_sel      (wb_sel),
      .busy        (busy),
      .halted      (halted),
`ifdef SEQ_PERF_COUNTERS_EN
      .instr_retired (instr_retired),
      .stall_cycles  (stall_cycles),
`endif
      .error       (error)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   // Completes a FETCH with immediate ready; leaves the DUT in DECODE.
   task automatic fetch(input logic [15:0] w);
      instr     = w;
      mem_ready = 1'b1;
      #1;
      check("fetch_ir_load", 16'(ir_load), 16'd1);
      check("fetch_pc_inc", 16'(pc_inc), 16'd1);
      check("fetch_we", 16'(mem_we), 16'd0);
      go();
      mem_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b1; alu_zero = 1'b0; instr = 16'hFFFF;
      go(); go();
      check("rst_mem_req", 16'(mem_req), 16'd0);
      check("rst_ir_load", 16'(ir_load), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_halted", 16'(halted), 16'd0);
      check("rst_error", 16'(error), 16'd0);

      // Program ADD, ST (2 waits), NOP, HALT
      rst_n = 1'b1; mem_ready = 1'b0; start = 1'b1;
      #1;
      check("idle_busy", 16'(busy), 16'd0);
      go(); start = 1'b0;
      check("fetch_busy", 16'(busy), 16'd1);
      fetch(16'h1100);
      check("decode_req", 16'(mem_req), 16'd0);
      go();
      check("add_alu_op", 16'(alu_op), 16'd0);
      check("add_src", 16'(alu_src_imm), 16'd0);
      go();
      check("add_reg_we", 16'(reg_we), 16'd1);
      go();
      fetch(16'h7205);
      go();
      check("st_src", 16'(alu_src_imm), 16'd1);
      go();
      for (int i = 0; i < 2; i++) begin
         check("st_req", 16'(mem_req), 16'd1);
         check("st_we", 16'(mem_we), 16'd1);
         go();
      end
      mem_ready = 1'b1;
      #1;
      check("st_req_ready", 16'(mem_req), 16'd1);
      go(); mem_ready = 1'b0;
      check("st_back_fetch", 16'(mem_req), 16'd1);
      check("st_no_wb", 16'(reg_we), 16'd0);
      fetch(16'h0000);
      go();
      fetch(16'hF000);
      go();
      check("halt_halted", 16'(halted), 16'd1);
      check("halt_busy", 16'(busy), 16'd0);
      for (int i = 0; i < 3; i++) begin
         start = ~start;
         go();
         check("halt_sticky", 16'(halted), 16'd1);
      end
      start = 1'b0;
`ifdef SEQ_PERF_COUNTERS_EN
      check("perf_retired", instr_retired, 16'd3);
      check("perf_stall", stall_cycles, 16'd2);
`endif
      rst_n = 1'b0; go(); rst_n = 1'b1;

      // ADDI, LD with 3 waits, BEQ taken / not taken
      start = 1'b1; go(); start = 1'b0;
      fetch(16'h5103);
      go();
      check("addi_src", 16'(alu_src_imm), 16'd1);
      check("addi_alu_op", 16'(alu_op), 16'd0);
      go();
      check("addi_reg_we", 16'(reg_we), 16'd1);
      check("addi_wb_sel", 16'(wb_sel), 16'd0);
      go();
      check("addi_back_fetch", 16'(mem_req), 16'd1);
      check("fetch_wait_no_load", 16'(ir_load), 16'd0);
      fetch(16'h62FE);
      go();
      check("ld_src", 16'(alu_src_imm), 16'd1);
      go();
      for (int i = 0; i < 3; i++) begin
         check("ld_req", 16'(mem_req), 16'd1);
         check("ld_we", 16'(mem_we), 16'd0);
         check("ld_no_err", 16'(error), 16'd0);
         go();
      end
      mem_ready = 1'b1;
      #1;
      check("ld_req_ready", 16'(mem_req), 16'd1);
      go(); mem_ready = 1'b0;
      check("ld_reg_we", 16'(reg_we), 16'd1);
      check("ld_wb_sel", 16'(wb_sel), 16'd1);
      go();
      fetch(16'h80F0);
      go();
      alu_zero = 1'b1;
      #1;
      check("beq_t_pc_load", 16'(pc_load), 16'd1);
      check("beq_alu_op", 16'(alu_op), 16'd1);
      check("beq_src", 16'(alu_src_imm), 16'd0);
      go(); alu_zero = 1'b0;
      check("beq_t_fetch", 16'(mem_req), 16'd1);
      fetch(16'h80F0);
      go();
      check("beq_nt_pc_load", 16'(pc_load), 16'd0);
      go();
      check("beq_nt_fetch", 16'(mem_req), 16'd1);

      // Reset in FETCH while memory is ready
      mem_ready = 1'b1; rst_n = 1'b0;
      #1;
      check("rst_mid_req", 16'(mem_req), 16'd0);
      check("rst_mid_ir_load", 16'(ir_load), 16'd0);
      go(); rst_n = 1'b1; mem_ready = 1'b0;
      #1;
      check("rst_mid_idle", 16'(busy), 16'd0);
      check("rst_mid_idle_req", 16'(mem_req), 16'd0);

      // Illegal opcode
      start = 1'b1; go(); start = 1'b0;
      fetch(16'hA000);
      go();
      check("illegal_error", 16'(error), 16'd1);
      check("illegal_busy", 16'(busy), 16'd0);
      rst_n = 1'b0; go(); rst_n = 1'b1;
      #1;
      check("illegal_cleared", 16'(error), 16'd0);

      // Fetch timeout after 4 wait cycles
      start = 1'b1; go(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("to_wait_req", 16'(mem_req), 16'd1);
         check("to_wait_no_err", 16'(error), 16'd0);
         go();
      end
      check("to_error", 16'(error), 16'd1);
      check("to_busy", 16'(busy), 16'd0);
      check("to_req_off", 16'(mem_req), 16'd0);
      for (int i = 0; i < 4; i++) begin
         start = ~start;
         go();
         check("to_sticky", 16'(error), 16'd1);
      end
      start = 1'b0; rst_n = 1'b0;
      #1;
      check("to_rst_req", 16'(mem_req), 16'd0);
      go(); rst_n = 1'b1;
      #1;
      check("to_rst_idle_err", 16'(error), 16'd0);
      check("to_rst_idle_busy", 16'(busy), 16'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
